// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI definitions for the read traffic generator slice:
//   - AXI burst type encodings (FIXED / INCR / WRAP)
//   - AXI response encodings (OKAY / EXOKAY / SLVERR / DECERR)
//   - generator FSM state type and state constants
//   - helper to derive AxSIZE from a data bus width
// No ports; imported by every file of the slice.
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Plain vector type with named constants so the state register stays
    // compatible with older tool flows that dislike enum-typed flops.
    typedef logic [1:0] gen_state_t;
    localparam gen_state_t ST_IDLE  = 2'd0;
    localparam gen_state_t ST_ISSUE = 2'd1;
    localparam gen_state_t ST_DRAIN = 2'd2;
    localparam gen_state_t ST_DONE  = 2'd3;

    // AxSIZE is log2 of the number of bytes per beat.
    function automatic logic [2:0] axi_size_of(input int dataW);
        return 3'($clog2(dataW / 8));
    endfunction

endpackage

// File: rtl/axi_rd_traffic_gen_if.sv
// ---------------------------------------------------------------------------
// axi_rd_traffic_gen_if
// AXI read address (AR) and read data (R) channels bundled as one interface.
//   master modport: drives AR + rready, receives arready + R
//   slave  modport: the mirror image, for a memory or a bench model
// Parameters: ADDR_W, DATA_W, ID_W set the bus widths.
// ---------------------------------------------------------------------------
interface axi_rd_traffic_gen_if
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int ID_W   = 7
);

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_rd_checker.sv
// ---------------------------------------------------------------------------
// axi_rd_checker
// Watches accepted R beats and keeps the per-run statistics.
//   i_clk, i_reset   : clock, asynchronous active-high reset
//   i_clear          : zero all statistics (start of a new run)
//   i_beat_valid     : an R handshake happens this cycle
//   i_rid/i_rdata/i_rresp/i_rlast : R channel payload of that beat
//   i_len            : arlen of the current run (beats per burst minus one)
//   o_beat_cnt       : accepted beats, wraps
//   o_err_cnt        : erroneous beats, saturates at 16'hFFFF
//   o_rdata_xor      : XOR fold of every accepted rdata word
// ---------------------------------------------------------------------------
module axi_rd_checker
    import axi_pkg::*;
#(
    parameter int ID_W   = 7,
    parameter int DATA_W = 256,
    parameter int GEN_ID = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_beat_valid,
    input  logic [ID_W-1:0]   i_rid,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic              i_rlast,
    input  logic [7:0]        i_len,
    output logic [31:0]       o_beat_cnt,
    output logic [15:0]       o_err_cnt,
    output logic [DATA_W-1:0] o_rdata_xor
);

    // Beat index is wider than arlen so a burst whose rlast never shows up
    // keeps counting past len instead of aliasing back onto valid indices.
    logic [15:0]       beatIdx_q,  beatIdx_d;
    logic [31:0]       beatCnt_q,  beatCnt_d;
    logic [15:0]       errCnt_q,   errCnt_d;
    logic [DATA_W-1:0] rdataXor_q, rdataXor_d;
    logic              beatErr;
    logic [15:0]       lenWide;

    assign lenWide = {8'd0, i_len};

    // All error causes are OR-ed so a beat with several faults counts once.
    assign beatErr = (i_rresp != AXI_RESP_OKAY)
                   || (i_rid != ID_W'(GEN_ID))
                   || ( i_rlast && (beatIdx_q <  lenWide))
                   || (!i_rlast && (beatIdx_q == lenWide));

    // Statistics update: a clear wins over a beat arriving in the same cycle,
    // and any rlast (early or on time) closes the burst for indexing.
    always_comb begin
        beatIdx_d  = beatIdx_q;
        beatCnt_d  = beatCnt_q;
        errCnt_d   = errCnt_q;
        rdataXor_d = rdataXor_q;
        if (i_clear) begin
            beatIdx_d  = '0;
            beatCnt_d  = '0;
            errCnt_d   = '0;
            rdataXor_d = '0;
        end else if (i_beat_valid) begin
            beatCnt_d  = beatCnt_q + 32'd1;
            rdataXor_d = rdataXor_q ^ i_rdata;
            if (beatErr && (errCnt_q != 16'hFFFF)) begin
                errCnt_d = errCnt_q + 16'd1;
            end
            beatIdx_d = i_rlast ? 16'd0 : beatIdx_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            beatIdx_q  <= '0;
            beatCnt_q  <= '0;
            errCnt_q   <= '0;
            rdataXor_q <= '0;
        end else begin
            beatIdx_q  <= beatIdx_d;
            beatCnt_q  <= beatCnt_d;
            errCnt_q   <= errCnt_d;
            rdataXor_q <= rdataXor_d;
        end
    end

    assign o_beat_cnt  = beatCnt_q;
    assign o_err_cnt   = errCnt_q;
    assign o_rdata_xor = rdataXor_q;

endmodule

// File: rtl/axi_rd_traffic_gen.sv
// ---------------------------------------------------------------------------
// axi_rd_traffic_gen
// Issues a run of INCR read bursts at base + k*stride, keeps up to MAX_OUT
// of them in flight and folds the returned data through axi_rd_checker.
//   i_clk, i_reset  : clock, asynchronous active-high reset
//   i_start         : one-cycle start pulse, honoured only when idle
//   i_base_addr     : address of the first burst
//   i_stride        : address increment between bursts (wraps silently)
//   i_num_bursts    : bursts in the run (0 completes immediately)
//   i_len           : arlen used for every burst
//   o_busy          : run in progress
//   o_done          : one-cycle completion pulse
//   o_beat_cnt, o_err_cnt, o_rdata_xor : run statistics, held until next run
//   axi             : AR/R channels (master side)
// ---------------------------------------------------------------------------
module axi_rd_traffic_gen
    import axi_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int ID_W    = 7,
    parameter int MAX_OUT = 4,
    parameter int GEN_ID  = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [ADDR_W-1:0]    i_base_addr,
    input  logic [ADDR_W-1:0]    i_stride,
    input  logic [15:0]          i_num_bursts,
    input  logic [7:0]           i_len,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [31:0]          o_beat_cnt,
    output logic [15:0]          o_err_cnt,
    output logic [DATA_W-1:0]    o_rdata_xor,
    axi_rd_traffic_gen_if.master axi
);

    localparam logic [2:0] AR_SIZE   = axi_size_of(DATA_W);
    localparam logic [4:0] MAX_OUT_C = 5'(MAX_OUT);

    gen_state_t        state_q,       state_d;
    logic [ADDR_W-1:0] araddr_q,      araddr_d;
    logic [ADDR_W-1:0] stride_q,      stride_d;
    logic [15:0]       numBursts_q,   numBursts_d;
    logic [7:0]        len_q,         len_d;
    logic [15:0]       issued_q,      issued_d;
    logic [4:0]        outstanding_q, outstanding_d;

    logic arValid;
    logic rReady;
    logic arHs;
    logic rHs;
    logic rLastDec;
    logic clearStats;

    // arvalid depends only on registered state, so once raised it can only
    // fall through a handshake, which keeps the AR payload stable while stalled.
    assign arValid  = (state_q == ST_ISSUE)
                    && (issued_q < numBursts_q)
                    && (outstanding_q < MAX_OUT_C);
    assign rReady   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign arHs     = arValid && axi.arready;
    assign rHs      = axi.rvalid && rReady;
    // A stray rlast with nothing in flight must not underflow the counter.
    assign rLastDec = rHs && axi.rlast && (outstanding_q != 5'd0);

    // Next-state logic: AR bookkeeping first, then FSM transitions; the idle
    // branch reloads the run configuration and overrides the bookkeeping.
    always_comb begin
        state_d       = state_q;
        araddr_d      = araddr_q;
        stride_d      = stride_q;
        numBursts_d   = numBursts_q;
        len_d         = len_q;
        issued_d      = issued_q;
        outstanding_d = outstanding_q;
        clearStats    = 1'b0;

        if (arHs) begin
            issued_d = issued_q + 16'd1;
            araddr_d = araddr_q + stride_q;
        end
        if (arHs && !rLastDec) begin
            outstanding_d = outstanding_q + 5'd1;
        end else if (!arHs && rLastDec) begin
            outstanding_d = outstanding_q - 5'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    araddr_d      = i_base_addr;
                    stride_d      = i_stride;
                    numBursts_d   = i_num_bursts;
                    len_d         = i_len;
                    issued_d      = '0;
                    outstanding_d = '0;
                    clearStats    = 1'b1;
                    state_d       = (i_num_bursts == 16'd0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (arHs && (issued_d == numBursts_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (outstanding_q == 5'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            araddr_q      <= '0;
            stride_q      <= '0;
            numBursts_q   <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            araddr_q      <= araddr_d;
            stride_q      <= stride_d;
            numBursts_q   <= numBursts_d;
            len_q         <= len_d;
            issued_q      <= issued_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign axi.arid    = ID_W'(GEN_ID);
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = AR_SIZE;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arvalid = arValid;
    assign axi.rready  = rReady;

    assign o_busy = rReady;
    assign o_done = (state_q == ST_DONE);

    axi_rd_checker #(
        .ID_W   (ID_W),
        .DATA_W (DATA_W),
        .GEN_ID (GEN_ID)
    ) u_checker (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (clearStats),
        .i_beat_valid (rHs),
        .i_rid        (axi.rid),
        .i_rdata      (axi.rdata),
        .i_rresp      (axi.rresp),
        .i_rlast      (axi.rlast),
        .i_len        (len_q),
        .o_beat_cnt   (o_beat_cnt),
        .o_err_cnt    (o_err_cnt),
        .o_rdata_xor  (o_rdata_xor)
    );

endmodule

// File: tb/tb_axi_rd_traffic_gen.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_traffic_gen
// Directed bench for axi_rd_traffic_gen. A reactive slave model answers the
// main instance; a second instance with MAX_OUT=2 is driven by hand to look
// at the outstanding limit. Expected AR addresses live in a queue filled
// when a run is started and drained as AR handshakes are observed.
// ---------------------------------------------------------------------------
module tb_axi_rd_traffic_gen;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int ID_W   = 7;
    localparam int GEN_ID = 5;

    logic              clk;
    logic              rst;
    logic              start,  start2;
    logic [31:0]       baseAddr, stride;
    logic [15:0]       numBursts, numBursts2;
    logic [7:0]        len, len2;
    logic              busy,  busy2;
    logic              done,  done2;
    logic [31:0]       beatCnt, beatCnt2;
    logic [15:0]       errCnt, errCnt2;
    logic [DATA_W-1:0] rdataXor, rdataXor2;

    int testsRun = 0;
    int failCnt  = 0;

    axi_rd_traffic_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi0 ();
    axi_rd_traffic_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi1 ();

    axi_rd_traffic_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUT(4), .GEN_ID(GEN_ID)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_base_addr(baseAddr),
        .i_stride(stride), .i_num_bursts(numBursts), .i_len(len),
        .o_busy(busy), .o_done(done), .o_beat_cnt(beatCnt), .o_err_cnt(errCnt),
        .o_rdata_xor(rdataXor), .axi(axi0)
    );

    axi_rd_traffic_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUT(2), .GEN_ID(GEN_ID)
    ) dut2 (
        .i_clk(clk), .i_reset(rst), .i_start(start2), .i_base_addr(baseAddr),
        .i_stride(stride), .i_num_bursts(numBursts2), .i_len(len2),
        .o_busy(busy2), .o_done(done2), .o_beat_cnt(beatCnt2), .o_err_cnt(errCnt2),
        .o_rdata_xor(rdataXor2), .axi(axi1)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave model configuration, written by the directed sequence.
    bit         slvArreadyRand;
    bit         slvREnable;
    int         slvBeatLimit;
    int         slvEarlyBurst, slvEarlyBeat;
    int         slvBadIdBurst, slvBadIdBeat;
    logic [1:0] slvResp;
    logic [7:0] slvLen;

    // Slave model state and scoreboard.
    int                pendBursts, servBurst, servBeat, beatsServed;
    bit                arPend, rPend, stallPend;
    logic [31:0]       arAddrCap, stallAddr;
    logic [7:0]        arLenCap;
    logic [DATA_W-1:0] expXor;
    int                expBeats, doneCnt, arCnt, doneStart, arStart;
    logic [31:0]       expAddrQ[$];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCnt++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reactive slave for the main instance. Everything happens at the falling
    // edge: first account for the handshakes predicted one cycle earlier, then
    // drive new channel values, then predict the handshakes of the next edge.
    initial begin
        axi0.arready = 1'b0;
        axi0.rvalid  = 1'b0;
        axi0.rlast   = 1'b0;
        axi0.rid     = '0;
        axi0.rresp   = '0;
        axi0.rdata   = '0;
        pendBursts = 0; servBurst = 0; servBeat = 0; beatsServed = 0;
        arPend = 0; rPend = 0; stallPend = 0;
        doneCnt = 0; arCnt = 0; expBeats = 0; expXor = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pendBursts = 0; servBurst = 0; servBeat = 0; beatsServed = 0;
                arPend = 0; rPend = 0; stallPend = 0;
                axi0.arready = 1'b0;
                axi0.rvalid  = 1'b0;
                axi0.rlast   = 1'b0;
            end else begin
                if (done) doneCnt++;
                if (arPend) begin
                    arCnt++;
                    pendBursts++;
                    if (expAddrQ.size() == 0) checkOutput("ar_unexpected", 64'd1, 64'd0);
                    else checkOutput("araddr", 64'(arAddrCap), 64'(expAddrQ.pop_front()));
                    checkOutput("arlen", 64'(arLenCap), 64'(slvLen));
                end
                if (stallPend && axi0.arvalid) begin
                    checkOutput("araddr_stable", 64'(axi0.araddr), 64'(stallAddr));
                end
                if (rPend) begin
                    expBeats++;
                    expXor ^= axi0.rdata;
                    beatsServed++;
                    if (axi0.rlast) begin
                        pendBursts--;
                        servBurst++;
                        servBeat = 0;
                    end else begin
                        servBeat++;
                    end
                end
                axi0.arready = slvArreadyRand ? 1'($urandom_range(0, 1)) : 1'b1;
                if (slvREnable && pendBursts > 0 &&
                    (slvBeatLimit < 0 || beatsServed < slvBeatLimit)) begin
                    axi0.rvalid = 1'b1;
                    axi0.rdata  = {$urandom, $urandom};
                    axi0.rresp  = slvResp;
                    axi0.rid    = (servBurst == slvBadIdBurst && servBeat == slvBadIdBeat)
                                  ? ID_W'(GEN_ID + 1) : ID_W'(GEN_ID);
                    axi0.rlast  = (servBurst == slvEarlyBurst) ? (servBeat == slvEarlyBeat)
                                                               : (servBeat == int'(slvLen));
                end else begin
                    axi0.rvalid = 1'b0;
                    axi0.rlast  = 1'b0;
                end
                arPend    = axi0.arvalid && axi0.arready;
                arAddrCap = axi0.araddr;
                arLenCap  = axi0.arlen;
                stallPend = axi0.arvalid && !axi0.arready;
                stallAddr = axi0.araddr;
                rPend     = axi0.rvalid && axi0.rready;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic resetSlaveCfg();
        slvArreadyRand = 0;
        slvREnable     = 1;
        slvBeatLimit   = -1;
        slvEarlyBurst  = -1;
        slvEarlyBeat   = -1;
        slvBadIdBurst  = -1;
        slvBadIdBeat   = -1;
        slvResp        = 2'b00;
    endtask

    // Loads the expected address sequence and pulses start on the main DUT.
    task automatic applyStimulus(input logic [31:0] base, input logic [31:0] strd,
                                 input logic [15:0] num, input logic [7:0] l);
        logic [31:0] a;
        slvLen = l;
        expAddrQ.delete();
        a = base;
        for (int k = 0; k < int'(num); k++) begin
            expAddrQ.push_back(a);
            a = a + strd;
        end
        expBeats = 0; expXor = '0; servBurst = 0; servBeat = 0; beatsServed = 0;
        doneStart = doneCnt;
        arStart   = arCnt;
        baseAddr  = base;
        stride    = strd;
        numBursts = num;
        len       = l;
        start     = 1'b1;
        step(1);
        start     = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int limit);
        int n;
        n = 0;
        while (doneCnt == doneStart && n < limit) begin
            step(1);
            n++;
        end
        checkOutput({tag, "_timeout"}, 64'(doneCnt == doneStart), 64'd0);
        step(3);
        checkOutput({tag, "_done_pulses"}, 64'(doneCnt - doneStart), 64'd1);
    endtask

    task automatic checkRun(input string tag, input int num, input int beats, input int errs);
        checkOutput({tag, "_ar_count"}, 64'(arCnt - arStart), 64'(num));
        checkOutput({tag, "_addr_left"}, 64'(expAddrQ.size()), 64'd0);
        checkOutput({tag, "_beat_cnt"}, 64'(beatCnt), 64'(beats));
        checkOutput({tag, "_beat_model"}, 64'(expBeats), 64'(beats));
        checkOutput({tag, "_err_cnt"}, 64'(errCnt), 64'(errs));
        checkOutput({tag, "_xor"}, 64'(rdataXor), 64'(expXor));
        checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
        checkOutput({tag, "_rready_after"}, 64'(axi0.rready), 64'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_arvalid"}, 64'(axi0.arvalid), 64'd0);
        checkOutput({tag, "_rready"}, 64'(axi0.rready), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_beat_cnt"}, 64'(beatCnt), 64'd0);
        checkOutput({tag, "_err_cnt"}, 64'(errCnt), 64'd0);
        checkOutput({tag, "_xor"}, 64'(rdataXor), 64'd0);
        checkOutput({tag, "_araddr"}, 64'(axi0.araddr), 64'd0);
        checkOutput({tag, "_arlen"}, 64'(axi0.arlen), 64'd0);
        checkOutput({tag, "_arid"}, 64'(axi0.arid), 64'(GEN_ID));
        checkOutput({tag, "_arsize"}, 64'(axi0.arsize), 64'd3);
        checkOutput({tag, "_arburst"}, 64'(axi0.arburst), 64'd1);
    endtask

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        int ar2;
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        baseAddr = '0; stride = '0; numBursts = '0; len = '0;
        numBursts2 = '0; len2 = '0; slvLen = '0;
        axi1.arready = 1'b0; axi1.rvalid = 1'b0; axi1.rlast = 1'b0;
        axi1.rid = '0; axi1.rresp = '0; axi1.rdata = '0;
        resetSlaveCfg();
        step(2);
        checkResetState("reset");
        rst = 1'b0;
        step(2);

        // Basic run; a second start while busy must be ignored.
        applyStimulus(32'h0000_1000, 32'h40, 16'd4, 8'd1);
        step(1);
        checkOutput("basic_busy", 64'(busy), 64'd1);
        baseAddr = 32'h0000_9000; numBursts = 16'd1; start = 1'b1;
        step(1);
        start = 1'b0;
        waitDone("basic", 200);
        checkRun("basic", 4, 8, 0);
        step(5);
        checkOutput("basic_hold_beats", 64'(beatCnt), 64'd8);

        // Early rlast on the third beat of burst 0.
        resetSlaveCfg();
        slvEarlyBurst = 0; slvEarlyBeat = 2;
        applyStimulus(32'h0000_2000, 32'h80, 16'd2, 8'd3);
        waitDone("early_last", 200);
        checkRun("early_last", 2, 7, 1);

        // SLVERR on every beat.
        resetSlaveCfg();
        slvResp = 2'b10;
        applyStimulus(32'h0000_3000, 32'h80, 16'd2, 8'd3);
        waitDone("slverr", 200);
        checkRun("slverr", 2, 8, 8);

        // One beat with a foreign rid.
        resetSlaveCfg();
        slvBadIdBurst = 1; slvBadIdBeat = 1;
        applyStimulus(32'h0000_3000, 32'h80, 16'd2, 8'd3);
        waitDone("bad_id", 200);
        checkRun("bad_id", 2, 8, 1);

        // Address wrap with random AR backpressure.
        resetSlaveCfg();
        slvArreadyRand = 1;
        applyStimulus(32'hFFFF_FFC0, 32'h40, 16'd2, 8'd0);
        waitDone("wrap", 300);
        checkRun("wrap", 2, 2, 0);
        step(5);
        checkOutput("wrap_hold_beats", 64'(beatCnt), 64'd2);

        // Zero bursts: straight to done, counters cleared.
        resetSlaveCfg();
        applyStimulus(32'h0000_7000, 32'h40, 16'd0, 8'd0);
        waitDone("zero", 20);
        checkRun("zero", 0, 0, 0);

        // Outstanding limit on the MAX_OUT=2 instance, R withheld.
        axi1.arready = 1'b1;
        baseAddr = 32'h0000_2000; stride = 32'h10; numBursts2 = 16'd5; len2 = 8'd0;
        start2 = 1'b1;
        step(1);
        start2 = 1'b0;
        ar2 = 0;
        for (int i = 0; i < 12; i++) begin
            if (axi1.arvalid && axi1.arready) ar2++;
            step(1);
        end
        checkOutput("maxout_ar_count", 64'(ar2), 64'd2);
        checkOutput("maxout_arvalid_low", 64'(axi1.arvalid), 64'd0);
        checkOutput("maxout_busy", 64'(busy2), 64'd1);
        axi1.rvalid = 1'b1; axi1.rlast = 1'b1; axi1.rid = ID_W'(GEN_ID);
        axi1.rresp = 2'b00; axi1.rdata = 64'h1234_5678_9ABC_DEF0;
        step(1);
        axi1.rvalid = 1'b0; axi1.rlast = 1'b0;
        checkOutput("maxout_arvalid_again", 64'(axi1.arvalid), 64'd1);
        checkOutput("maxout_beat_cnt", 64'(beatCnt2), 64'd1);
        axi1.arready = 1'b0;

        // Reset with three bursts in flight.
        resetSlaveCfg();
        slvBeatLimit = 1;
        applyStimulus(32'h0000_4000, 32'h100, 16'd3, 8'd1);
        begin
            int n;
            n = 0;
            while ((arCnt - arStart) < 3 && n < 50) begin
                step(1);
                n++;
            end
        end
        checkOutput("midreset_ar_count", 64'(arCnt - arStart), 64'd3);
        step(2);
        checkOutput("midreset_pre_beats", 64'(beatCnt), 64'd1);
        checkOutput("midreset_pre_busy", 64'(busy), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        checkResetState("midreset");
        step(1);
        rst = 1'b0;
        doneStart = doneCnt;
        step(6);
        checkOutput("midreset_no_done", 64'(doneCnt - doneStart), 64'd0);
        resetSlaveCfg();
        applyStimulus(32'h0000_5000, 32'h20, 16'd2, 8'd1);
        waitDone("after_reset", 200);
        checkRun("after_reset", 2, 4, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
        $finish;
    end

endmodule

// File: doc/axi_rd_traffic_gen.md
AXI_RD_TRAFFIC_GEN -- requirements
Module: axi_rd_traffic_gen

Interface
REQ-001 SHALL have parameter ADDR_W, 32, AXI address width.
REQ-002 SHALL have parameter DATA_W, 256, AXI read data width, power of two, 8..1024.
REQ-003 SHALL have parameter ID_W, 7, AXI ID width.
REQ-004 SHALL have parameter MAX_OUT, 4, maximum outstanding read bursts, 1..16.
REQ-005 SHALL have parameter GEN_ID, 0, fixed arid value.
REQ-006 Ports (name  direction  width  meaning):
 i_clk  in  1  single clock, all logic rising-edge.
 i_reset  in  1  asynchronous active-high reset.
 i_start  in  1  one-cycle start pulse.
 i_base_addr  in  ADDR_W  first burst address.
 i_stride  in  ADDR_W  address increment per burst.
 i_num_bursts  in  16  bursts to issue.
 i_len  in  8  arlen for every burst.
 o_busy  out  1  run in progress.
 o_done  out  1  one-cycle completion pulse.
 o_beat_cnt  out  32  accepted R beats this run.
 o_err_cnt  out  16  saturating error count this run.
 o_rdata_xor  out  DATA_W  XOR fold of all accepted rdata this run.
 arid/araddr/arlen/arsize/arburst/arvalid  out  ID_W/ADDR_W/8/3/2/1  AXI AR channel.
 arready  in  1  AXI AR ready.
 rid/rdata/rresp/rlast/rvalid  in  ID_W/DATA_W/2/1/1  AXI R channel.
 rready  out  1  AXI R ready.

Function
REQ-007 FSM states IDLE, ISSUE, DRAIN, DONE; i_start in IDLE latches all i_* config and clears o_beat_cnt, o_err_cnt, o_rdata_xor, -> ISSUE.
REQ-008 i_start outside IDLE SHALL be ignored.
REQ-009 i_num_bursts==0: IDLE -> DONE directly, no AR issued.
REQ-010 ISSUE: arvalid asserted while issued<num_bursts and outstanding<MAX_OUT; araddr/arlen stable while arvalid && !arready.
REQ-011 AR handshake (arvalid&&arready) SHALL increment issued and outstanding and advance araddr by stride, modulo 2^ADDR_W (wrap silent).
REQ-012 arid=GEN_ID, arlen=latched i_len, arsize=log2(DATA_W/8), arburst=2'b01 (INCR), constant.
REQ-013 Last AR handshake: ISSUE -> DRAIN; DRAIN -> DONE when outstanding==0; DONE -> IDLE after one cycle with o_done=1.
REQ-014 rready=1 in ISSUE and DRAIN, 0 in IDLE and DONE.
REQ-015 Each R handshake: o_beat_cnt+1, o_rdata_xor ^= rdata, beat index +1.
REQ-016 R handshake with rlast=1: outstanding-1, beat index cleared; simultaneous AR and R-last handshakes leave outstanding unchanged.
REQ-017 Error +1 per beat if any of: rresp!=0, rid!=GEN_ID, rlast=1 with beat index<len, rlast=0 with beat index==len (each beat counts at most once).
REQ-018 Early rlast SHALL still close the burst; late rlast missing: beat index keeps counting, burst closes only on rlast.
REQ-019 o_err_cnt saturates at 16'hFFFF; o_beat_cnt wraps.
REQ-020 o_busy=1 in ISSUE and DRAIN only.
REQ-021 Counters and XOR hold final values after DONE until next accepted i_start.

Reset
REQ-022 i_reset asserted SHALL immediately force IDLE, arvalid=0, rready=0, o_busy=0, o_done=0, all counters/o_rdata_xor/araddr/arlen=0, arid=GEN_ID, arsize/arburst at REQ-012 values.
REQ-023 Reset mid-run SHALL abandon outstanding bursts; no done pulse.

Structure
REQ-024 Shared package axi_pkg SHALL hold AXI burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY/EXOKAY/SLVERR/DECERR), and FSM state typedef.
REQ-025 Single sub-module axi_rd_checker SHALL hold beat index, rlast/rresp/rid checks, counters and XOR fold; AR issue and FSM stay at top.

Verification
REQ-026 base=0x1000, stride=0x40, num=4, len=1, arready/rvalid always 1, clean data -> araddr 0x1000,0x1040,0x1080,0x10C0; beat_cnt=8; err_cnt=0; one o_done.
REQ-027 MAX_OUT=2, num=5, slave withholds R -> exactly 2 AR handshakes then arvalid=0 until first rlast.
REQ-028 len=3, slave asserts rlast on beat 2 of burst 0 -> err_cnt=1, run completes, beat_cnt reflects actual beats.
REQ-029 rresp=2'b10 on all 8 beats of num=2, len=3 -> err_cnt=8; rid=GEN_ID+1 on one beat -> +1.
REQ-030 base=0xFFFFFFC0, stride=0x40, num=2 -> araddr 0xFFFFFFC0 then 0x00000000.
REQ-031 i_reset pulsed with 3 bursts outstanding -> all outputs at reset values same cycle, no o_done; new i_start runs normally.
